mem_loader: RTL

- Runtime writer that fills the A10 register bank or instruction memory from a byte stream, in place of the simulation-only file preload.
- Assembles incoming bytes MSB-first into 32-bit words and writes them to consecutive addresses 0..DEPTH-1 through a single write port.
- Drives the processor's memory write side while the core is held off through `busy`; reports completion through `done`.

---
 rtl/mem_loader_pkg.sv | 16 +
 rtl/mem_loader_word_assembler.sv | 40 ++++
 rtl/mem_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the runtime memory loader: FSM encoding and the
// default geometry of the A10 register bank it fills.
package mem_loader_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
  localparam int LOAD_DEPTH     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Byte-to-word assembler: shifts bytes in MSB-first and counts them so the
// loader FSM knows when a full word is ready to be written.
module word_assembler #(
  parameter int DATA_W = mem_loader_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_full
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = $clog2(BPW + 1);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_shift;

  // Shift register and byte counter; clear only restarts the count, the
  // stale word is fully overwritten by the next BPW bytes anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_shift) begin
      r_shift <= {r_shift[DATA_W-9:0], i_byte};
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_word = r_shift;
  // Flags the transfer that completes the word, so the FSM can move to its
  // write cycle on this same edge and keep byte-to-write latency at one.
  assign o_word_full = i_shift && (r_count == CNT_W'(BPW - 1));

endmodule

// File: rtl/mem_loader.sv
// Runtime memory loader: assembles a byte stream into words and writes them
// to addresses 0..DEPTH-1, holding the core off through busy meanwhile.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = LOAD_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W:0]     r_word_count;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   w_word;
  logic                w_word_full;
  logic                w_xfer;
  logic                w_clear;
  logic                w_accept_start;
  logic                w_last_write;

  assign w_xfer         = in_valid && in_ready;
  assign w_accept_start = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_write   = (r_word_count == LAST_COUNT);

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_shift    (w_xfer),
    .i_byte     (in_byte),
    .o_word     (w_word),
    .o_word_full(w_word_full)
  );

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and Moore outputs; start is ignored while busy.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    wr_en        = 1'b0;
    done         = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = COLLECT;
          w_clear      = 1'b1;
        end
      end
      COLLECT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_word_full) w_next_state = WRITE;
      end
      WRITE: begin
        wr_en        = 1'b1;
        busy         = 1'b1;
        w_clear      = 1'b1;
        w_next_state = w_last_write ? DONE : COLLECT;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_next_state = COLLECT;
          w_clear      = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Address and word counters; the address saturates at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr    <= '0;
      r_word_count <= '0;
    end else if (w_accept_start) begin
      r_wr_addr    <= '0;
      r_word_count <= '0;
    end else if (r_state == WRITE) begin
      r_word_count <= r_word_count + (ADDR_W + 1)'(1);
      if (!w_last_write) r_wr_addr <= r_wr_addr + ADDR_W'(1);
    end
  end

  // Keep the last written word so wr_data does not follow the shift register
  // while the next word is being collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_wr_data <= '0;
    else if (r_state == WRITE)  r_wr_data <= w_word;
  end

  assign wr_data    = (r_state == WRITE) ? w_word : r_wr_data;
  assign wr_addr    = r_wr_addr;
  assign word_count = r_word_count;

endmodule
